// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: width, opcode tags, skid FSM states, flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic parity;
  } alu_flags_t;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational zero/negative/parity flags for one ALU result.
// Parity is only computed when ALU_RESULT_PARITY_EN is defined; otherwise it is tied low.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  always_comb begin
    flags      = '0;
    flags.zero = (result == '0);
    flags.neg  = result[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
    flags.parity = ^result;
`else
    flags.parity = 1'b0;
`endif
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry skid buffer and delivered-result counter.
// Optional ALU_RESULT_PARITY_EN adds a stored parity flag driven on out_parity.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | main register full, skid empty
// ST_TWO   | main and skid full, in_ready low
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
`ifdef ALU_RESULT_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_count
);

  skid_state_e      state;
  alu_flags_t       in_flags;
  logic             in_acc;
  logic             out_xfer;
  logic [WIDTH-1:0] skid_result;
  logic [1:0]       skid_op;
  logic             skid_zero;
  logic             skid_neg;
`ifdef ALU_RESULT_PARITY_EN
  logic             skid_parity;
`else
  logic             unused_parity;
  assign unused_parity = in_flags.parity;
`endif

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result (in_result),
    .flags  (in_flags)
  );

  assign in_acc   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_op      <= '0;
      out_zero    <= 1'b1;
      out_neg     <= 1'b0;
      skid_result <= '0;
      skid_op     <= '0;
      skid_zero   <= 1'b1;
      skid_neg    <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
      out_parity  <= 1'b0;
      skid_parity <= 1'b0;
`endif
      xfer_count  <= '0;
    end else begin
      if (out_xfer) xfer_count <= xfer_count + 1'b1;

      case (state)
        ST_EMPTY: begin
          if (in_acc) begin
            out_result <= in_result;
            out_op     <= in_op;
            out_zero   <= in_flags.zero;
            out_neg    <= in_flags.neg;
`ifdef ALU_RESULT_PARITY_EN
            out_parity <= in_flags.parity;
`endif
            out_valid  <= 1'b1;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_acc && out_xfer) begin
            out_result <= in_result;
            out_op     <= in_op;
            out_zero   <= in_flags.zero;
            out_neg    <= in_flags.neg;
`ifdef ALU_RESULT_PARITY_EN
            out_parity <= in_flags.parity;
`endif
          end else if (in_acc) begin
            skid_result <= in_result;
            skid_op     <= in_op;
            skid_zero   <= in_flags.zero;
            skid_neg    <= in_flags.neg;
`ifdef ALU_RESULT_PARITY_EN
            skid_parity <= in_flags.parity;
`endif
            in_ready    <= 1'b0;
            state       <= ST_TWO;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain into main can happen
          if (out_xfer) begin
            out_result <= skid_result;
            out_op     <= skid_op;
            out_zero   <= skid_zero;
            out_neg    <= skid_neg;
`ifdef ALU_RESULT_PARITY_EN
            out_parity <= skid_parity;
`endif
            in_ready   <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench: FIFO reference model compared every cycle, plus directed literal checks.
module tb_alu_result_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_op;
  logic             out_zero;
  logic             out_neg;
`ifdef ALU_RESULT_PARITY_EN
  logic             out_parity;
`endif
  logic [CNT_W-1:0] xfer_count;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity (out_parity),
`endif
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep FIFO of accepted results plus a transfer counter.
  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [1:0]       op;
  } entry_t;

  entry_t q[$];
  int     m_cnt = 0;
  bit     m_live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt  = 0;
      m_live = 1;
    end else if (m_live) begin
      bit acc, xfer;
      acc  = in_valid && (q.size() < 2);
      xfer = (q.size() > 0) && out_ready;
      if (xfer) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (acc) q.push_back('{r: in_result, op: in_op});
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
      if (q.size() > 0) begin
        chk("out_result", 64'(out_result), 64'(q[0].r));
        chk("out_op", 64'(out_op), 64'(q[0].op));
        chk("out_zero", 64'(out_zero), 64'(q[0].r == 0));
        chk("out_neg", 64'(out_neg), 64'(q[0].r[WIDTH-1]));
`ifdef ALU_RESULT_PARITY_EN
        chk("out_parity", 64'(out_parity), 64'(^q[0].r));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_op     = 2'd0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_zero", 64'(out_zero), 64'd1);
    chk("rst out_neg", 64'(out_neg), 64'd0);
    chk("rst out_result", 64'(out_result), 64'd0);
    chk("rst out_op", 64'(out_op), 64'd0);
    chk("rst xfer_count", 64'(xfer_count), 64'd0);
`ifdef ALU_RESULT_PARITY_EN
    chk("rst out_parity", 64'(out_parity), 64'd0);
`endif
    rst_n = 1'b1;

    // single XOR result, all ones
    a = 32'hFFFF0000;
    b = 32'h0000FFFF;
    in_valid = 1'b1; in_result = a ^ b; in_op = 2'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single result", 64'(out_result), 64'hFFFFFFFF);
    chk("single neg", 64'(out_neg), 64'd1);
    chk("single zero", 64'(out_zero), 64'd0);
    chk("single op", 64'(out_op), 64'd2);
`ifdef ALU_RESULT_PARITY_EN
    chk("single parity", 64'(out_parity), 64'd0);
`endif
    step();
    chk("single count", 64'(xfer_count), 64'd1);
    chk("single drained", 64'(out_valid), 64'd0);

    // backpressure: 1 and 2 buffered, 3 held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h1; in_op = 2'd3;
    step();
    in_result = 32'h2;
    step();
    chk("bp in_ready low", 64'(in_ready), 64'd0);
    in_result = 32'h3;
    step();
    step();
    chk("bp hold head", 64'(out_result), 64'h1);
    out_ready = 1'b1;
    step();
    chk("bp second", 64'(out_result), 64'h2);
    chk("bp ready back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp third", 64'(out_result), 64'h3);
    chk("bp no gap", 64'(out_valid), 64'd1);
    step();
    chk("bp count", 64'(xfer_count), 64'd4);

    // zero flag
    a = 32'hA5A5A5A5;
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = a ^ a; in_op = 2'd2;
    step();
    in_valid = 1'b0;
    chk("zero flag", 64'(out_zero), 64'd1);
    chk("zero neg", 64'(out_neg), 64'd0);
    out_ready = 1'b1;
    step();

    // 11 more transfers bring the 4-bit counter to 16 -> 0
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_result = 32'(i + 100); in_op = 2'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("count wrap", 64'(xfer_count), 64'd0);

    // reset while in TWO discards both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'hDEAD0001;
    step();
    in_result = 32'hDEAD0002;
    step();
    chk("two in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst2 out_valid", 64'(out_valid), 64'd0);
    chk("rst2 in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst2 stays empty", 64'(out_valid), 64'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: in_result = '0;
        1: in_result = 32'h80000000;
        2: in_result = 32'hFFFFFFFF;
        default: begin
          a = $urandom;
          b = $urandom;
          in_result = a ^ b;
        end
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
